// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the two-digit BCD scan counter.
// The master side drives enable/direction/clear and watches the display
// outputs; the slave side is the counter itself.
interface bcd_scan_counter_if;
    logic       iEn;
    logic       iUp;
    logic       iClear;
    logic [3:0] oData;
    logic [1:0] oSel;
    logic [7:0] oValue;
    logic       oCarry;

    modport master (
        output iEn,
        output iUp,
        output iClear,
        input  oData,
        input  oSel,
        input  oValue,
        input  oCarry
    );

    modport slave (
        input  iEn,
        input  iUp,
        input  iClear,
        output oData,
        output oSel,
        output oValue,
        output oCarry
    );
endinterface

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with a built-in digit-scan multiplexer.
// A prescaler turns the board clock into count ticks. Each digit is its own
// 4-bit BCD register, and the digits are chained by a ripple of "at limit"
// flags. A free-running scan counter alternates which digit is presented on
// oData, together with an active-low anode select, for a display7 decoder.
module bcd_scan_counter #(
    parameter int PRESCALE = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input logic               iClk,
    input logic               iRst,
    bcd_scan_counter_if.slave bus
);

    localparam int NUM_DIGITS = 2;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slotT;

    logic [PW-1:0]         pcntReg;
    logic [PW-1:0]         pcntNext;
    logic                  tick;

    logic [3:0]            digitReg  [NUM_DIGITS];
    logic [3:0]            digitNext [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] atLimit;
    logic [NUM_DIGITS-1:0] stepEn;
    logic                  carryReg;
    logic                  carryNext;

    logic [SW-1:0]         scntReg;
    logic [SW-1:0]         scntNext;
    logic                  scanWrap;
    slotT                  slotReg;
    slotT                  slotNext;

    // A tick fires on the last prescaler count of an enabled cycle.
    assign tick = bus.iEn && (pcntReg == PCNT_MAX);

    // Prescaler: clear wins, wrap on tick, otherwise advance only while enabled.
    always_comb begin
        pcntNext = pcntReg;
        if (bus.iClear) begin
            pcntNext = '0;
        end else if (tick) begin
            pcntNext = '0;
        end else if (bus.iEn) begin
            pcntNext = pcntReg + PW'(1);
        end
    end

    // Per-digit BCD step: a digit at its limit for the current direction
    // wraps (9->0 up, 0->9 down) and lets the step ripple to the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign atLimit[gi] = bus.iUp ? (digitReg[gi] == 4'd9)
                                         : (digitReg[gi] == 4'd0);

            assign digitNext[gi] =
                bus.iClear   ? 4'd0 :
                !stepEn[gi]  ? digitReg[gi] :
                bus.iUp      ? (atLimit[gi] ? 4'd0 : digitReg[gi] + 4'd1)
                             : (atLimit[gi] ? 4'd9 : digitReg[gi] - 4'd1);
        end
    endgenerate

    // Ripple chain: digit i steps when the tick reaches it through all lower
    // digits sitting at their limit; falling off the top is the wrap carry.
    always_comb begin
        logic ripple;
        ripple    = tick;
        stepEn    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            stepEn[i] = ripple;
            ripple    = ripple & atLimit[i];
        end
        carryNext = ripple & ~bus.iClear;
    end

    // Count state: prescaler, digit registers and the one-cycle carry pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pcntReg  <= '0;
            carryReg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digitReg[i] <= 4'd0;
            end
        end else begin
            pcntReg  <= pcntNext;
            carryReg <= carryNext;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digitReg[i] <= digitNext[i];
            end
        end
    end

    // Scan divider runs freely; enable and clear never touch it.
    assign scanWrap = (scntReg == SCNT_MAX);
    assign scntNext = scanWrap ? '0 : scntReg + SW'(1);

    // Scan state register: divider and the currently displayed slot.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            scntReg <= '0;
            slotReg <= SLOT_ONES;
        end else begin
            scntReg <= scntNext;
            slotReg <= slotNext;
        end
    end

    // Slot next-state and display decode; outputs come from registers only,
    // so a tick coinciding with a slot change shows the new digit at once.
    always_comb begin
        slotNext   = slotReg;
        bus.oSel   = 2'b10;
        bus.oData  = digitReg[0];
        if (scanWrap) begin
            slotNext = (slotReg == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end
        if (slotReg == SLOT_TENS) begin
            bus.oSel  = 2'b01;
            bus.oData = digitReg[1];
        end
    end

    assign bus.oValue = {digitReg[1], digitReg[0]};
    assign bus.oCarry = carryReg;

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Two-digit BCD up/down counter with a built-in digit-scan multiplexer. Sits directly upstream of the `display7` seven-segment decoder. It produces one 4-bit BCD nibble at a time on `oData`, which connects straight to `display7.iData`, together with an active-low digit-select pair that drives the display anodes. The count advances on a prescaled tick, so a board clock yields a human-visible count.

## Interface
- `PRESCALE`, default 100_000_000: enabled clock cycles per count step; legal range ≥ 1.
- `SCAN_DIV`, default 100_000: clock cycles each digit is shown before the scan switches; legal range ≥ 1.
- `iClk`  in  1  single clock; all state changes on the rising edge.
- `iRst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `iEn`  in  1  count enable; the prescaler runs only while high.
- `iUp`  in  1  direction: 1 = up, 0 = down; sampled on the tick cycle.
- `iClear`  in  1  synchronous clear of the count and the prescaler.
- `oData`  out  4  BCD nibble of the currently scanned digit; feeds `display7.iData`.
- `oSel`  out  2  active-low digit select: 2'b10 = ones digit, 2'b01 = tens digit.
- `oValue`  out  8  full count, {tens, ones}, each 0–9.
- `oCarry`  out  1  one-cycle pulse on wrap: 99→00 when counting up, 00→99 when counting down.

## Operation
- **Prescaler.** The prescaler `pcnt` counts 0..PRESCALE-1 while `iEn`=1 and holds while `iEn`=0.
  - Its width is ceil(log2(PRESCALE)), minimum 1 bit.
  - `tick` = `iEn` & (`pcnt` == PRESCALE-1). On a tick, `pcnt` returns to 0.
  - With PRESCALE=1, `tick` = `iEn`, so the count moves every enabled cycle.
- **Counting up on a tick.** If ones < 9, ones+1. Otherwise ones=0 and tens steps: if tens < 9, tens+1; otherwise tens=0 and `oCarry`=1.
- **Counting down on a tick.** If ones > 0, ones-1. Otherwise ones=9 and tens steps: if tens > 0, tens-1; otherwise tens=9 and `oCarry`=1.
- Digits never hold values 10–15. Each digit is a separate 4-bit BCD register, not a binary counter that gets converted.
- **Clear.** `iClear`=1 takes priority over a tick in the same cycle: ones=0, tens=0, `pcnt`=0, `oCarry`=0. The scan logic is not affected by `iClear`.
- **Scan.** The free-running counter `scnt` counts 0..SCAN_DIV-1, independent of `iEn` and `iClear`.
  - When `scnt` reaches SCAN_DIV-1, it returns to 0 and the `slot` register toggles.
  - `slot`=0: `oSel`=2'b10, `oData`=ones. `slot`=1: `oSel`=2'b01, `oData`=tens.
- `oData`, `oSel` and `oValue` are decoded combinationally from registers only, with no input-to-output path.
- `oCarry` is a register, high for exactly the one cycle after the wrapping edge.
- **Direction change.** A change on `iUp` between ticks takes effect at the next tick; no state is lost.

## Timing
- **Reset values (while `iRst`=1, asynchronously):**
  - registers: `pcnt`=0, `scnt`=0, `slot`=0, ones=0, tens=0;
  - outputs: `oData`=4'h0, `oSel`=2'b10, `oValue`=8'h00, `oCarry`=0.
- **Reset release.** After `iRst` falls, the first rising edge is the first active edge.
- **First tick.** With `iEn` held high from release, the first tick occurs on the edge that ends cycle PRESCALE. `oValue` changes right after that edge, and ticks then repeat every PRESCALE cycles.
- **`iEn` low mid-period.** Dropping `iEn` freezes `pcnt`. Raising it again resumes the count from the same `pcnt` value; the period is not restarted.
- **Slot period.** Each slot lasts exactly SCAN_DIV cycles, and `oSel` is never 2'b11 or 2'b00 after reset.
- **Reset mid-period.** Asserting `iRst` mid-tick or mid-scan clears everything in the same cycle; no partial update survives.
- **Count change mid-slot.** If a tick and a slot change fall on the same edge, `oData` shows the new digit of the new slot right after that edge.

## Test plan
Use PRESCALE=3 and SCAN_DIV=2 for every scenario.
1. Reset, then `iEn`=1, `iUp`=1 for 30 cycles → `oValue` steps 00,01,…,10 at cycles 3,6,…,30; `oCarry` stays 0.
2. Preload 98 by ticking up 98 times, then take 2 more ticks → sequence 98→99→00; `oCarry`=1 for exactly one cycle after the 99→00 edge.
3. From 00 with `iUp`=0, take one tick → `oValue`=8'h99 and an `oCarry` pulse; the next tick gives 98, and 10→09 decrements tens correctly.
4. Count to 37, then watch `oSel`/`oData` → they alternate every 2 cycles between (2'b10, 7) and (2'b01, 3), with `oSel` never 2'b11.
5. Assert `iClear` on a tick cycle at value 45 → next `oValue`=00, `pcnt` restarts, and the next tick arrives 3 enabled cycles later. Separately, drop `iEn` for 5 cycles mid-period → the tick is delayed by exactly 5 cycles.
6. Assert `iRst` asynchronously between clock edges at value 62 → all outputs go to their reset values before the next edge.
